queue_load_scheduler: RTL and testbench
=======================================

QUEUE_LOAD_SCHEDULER -- requirements
Module: queue_load_scheduler

Interface
REQ-001 SHALL have parameter N, default 8, systolic array dimension, which is also the tile size per queue of N*N words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2*N, number of cycles to wait after both queues are empty before reporting done; legal range is 1 or more.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the RUN watchdog limit, used only when SCHED_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit, reset, synchronous and active-high.
REQ-007 SHALL have port go_i, input, 1 bit, job request; sampled only in IDLE.
REQ-008 SHALL have port in_valid_i, input, 1 bit, host word valid.
REQ-009 SHALL have port in_data_i, input, DATA_WIDTH bits, host word.
REQ-010 SHALL have port in_ready_o, output, 1 bit, host word accepted.
REQ-011 SHALL have ports col_we_o (output, 1), col_wdata_o (output, DATA_WIDTH) and col_wreset_o (output, 1): the column-queue write port.
REQ-012 SHALL have ports row_we_o (output, 1), row_wdata_o (output, DATA_WIDTH) and row_wreset_o (output, 1): the row-queue write port.
REQ-013 SHALL have ports col_start_o and row_start_o, output, 1 bit each, queue start pulses.
REQ-014 SHALL have ports col_empty_i and row_empty_i, input, 1 bit each, queue-empty status.
REQ-015 SHALL have port busy_o, output, 1 bit, high whenever the state is not IDLE.
REQ-016 SHALL have port done_o, output, 1 bit, one-cycle job-complete pulse.
REQ-017 SHALL have port err_o, output, 1 bit, sticky timeout flag.
REQ-018 SHALL have port state_o, output, 3 bits, current state encoding.

Function
REQ-019 SHALL implement the states IDLE=0, CLEAR=1, LOAD_COL=2, LOAD_ROW=3, START=4, RUN=5, DRAIN=6, DONE=7.
REQ-020 IDLE SHALL move to CLEAR on the cycle after go_i is sampled high; go_i is ignored in every other state.
REQ-021 CLEAR SHALL last exactly one cycle with col_wreset_o=row_wreset_o=1 and in_ready_o=0, then move to LOAD_COL.
REQ-022 in_ready_o SHALL equal 1 only in LOAD_COL and LOAD_ROW, combinationally from the state.
REQ-023 A handshake SHALL be in_valid_i & in_ready_o.
REQ-024 In LOAD_COL, col_we_o SHALL equal the handshake and col_wdata_o SHALL equal in_data_i, with zero-cycle latency.
REQ-025 In LOAD_ROW, row_we_o and row_wdata_o SHALL behave the same way as col_we_o and col_wdata_o do in LOAD_COL.
REQ-026 The *_wdata_o outputs SHALL be 0 whenever the matching *_we_o is 0.
REQ-027 A word counter of width clog2(N*N+1) SHALL increment per handshake and clear on every load-state exit.
REQ-028 The load state SHALL exit on the handshake that makes the count N*N: LOAD_COL moves to LOAD_ROW, and LOAD_ROW moves to START.
REQ-029 in_valid_i low SHALL stall loading indefinitely, with no timeout.
REQ-030 START SHALL last one cycle with col_start_o=row_start_o=1, then move to RUN.
REQ-031 RUN SHALL ignore col_empty_i and row_empty_i for its first 2 cycles.
REQ-032 After those 2 cycles, RUN SHALL move to DRAIN on the first cycle where col_empty_i & row_empty_i = 1; the two flags may rise in different cycles, and the move waits for both.
REQ-033 DRAIN SHALL count DRAIN_CYCLES cycles, then move to DONE.
REQ-034 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-035 go_i held high SHALL start the next job from IDLE on the following cycle.
REQ-036 The start, wreset and done outputs SHALL each be high for exactly one cycle per job.

Reset
REQ-037 When rst_i=1 at a clock edge, the state SHALL become IDLE and all counters SHALL clear.
REQ-038 On reset, err_o SHALL clear.
REQ-039 On reset, every output SHALL be 0, including in_ready_o, busy_o and state_o.
REQ-040 Reset asserted mid-job, in any state, SHALL abort the job with no done_o and no start pulse.
REQ-041 Reset SHALL take priority over go_i in the same cycle.

Configuration
REQ-042 With macro SCHED_TIMEOUT_EN defined, a RUN cycle counter SHALL count cycles spent in RUN.
REQ-043 With SCHED_TIMEOUT_EN defined, the RUN counter reaching TIMEOUT_CYCLES SHALL set err_o, which stays set until reset, and force a move to DONE, skipping DRAIN.
REQ-044 With SCHED_TIMEOUT_EN undefined, no RUN counter SHALL exist, err_o SHALL be tied to 0, and RUN SHALL wait indefinitely.

Verification
REQ-045 The bench SHALL cover: N=4, go pulse, 32 back-to-back valid words 0..31 -> wreset pulse 1 cycle after go; col_we for words 0..15, row_we for words 16..31; start pulse 1 cycle after word 31; done_o DRAIN_CYCLES+1 cycles after both empty.
REQ-046 The bench SHALL cover: in_valid_i toggling every other cycle -> exactly 16 col and 16 row writes, with no extra or dropped words.
REQ-047 The bench SHALL cover: col_empty_i high 5 cycles before row_empty_i -> DRAIN entered only when row_empty_i rises.
REQ-048 The bench SHALL cover: rst_i asserted in LOAD_ROW after 7 row words -> next cycle IDLE and all outputs 0; a new go then writes starting from col word 0.
REQ-049 The bench SHALL cover: go_i pulsed during RUN -> ignored; exactly one done_o.
REQ-050 The bench SHALL cover: SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=20 and empties held low -> err_o=1 and done_o 20 cycles into RUN; err_o persists until rst_i.

Source files
------------

// File: rtl/queue_load_scheduler.sv
// Job sequencer that clears, loads and starts the column/row operand queues of an
// N x N systolic array, then waits for drain. Optional RUN watchdog: SCHED_TIMEOUT_EN.
module queue_load_scheduler #(
  parameter int N              = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int DRAIN_CYCLES   = 2 * N,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  go_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  col_we_o,
  output logic [DATA_WIDTH-1:0] col_wdata_o,
  output logic                  col_wreset_o,
  output logic                  row_we_o,
  output logic [DATA_WIDTH-1:0] row_wdata_o,
  output logic                  row_wreset_o,
  output logic                  col_start_o,
  output logic                  row_start_o,
  input  logic                  col_empty_i,
  input  logic                  row_empty_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [2:0]            state_o
);

  localparam int WORDS   = N * N;
  localparam int CNT_W   = $clog2(WORDS + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_LOAD_COL = 3'd2,
    ST_LOAD_ROW = 3'd3,
    ST_START    = 3'd4,
    ST_RUN      = 3'd5,
    ST_DRAIN    = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [1:0]         run_hold_q;
  logic [DRAIN_W-1:0] drain_cnt_q;

  logic hs;
  logic load_last;
  logic run_settled;
  logic drain_last;
  logic timeout_hit;

  assign hs          = in_valid_i & in_ready_o;
  assign load_last   = hs && (word_cnt_q == CNT_W'(WORDS - 1));
  assign run_settled = (run_hold_q == 2'd2);
  assign drain_last  = (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1));

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The word count wraps to zero on the last word, which is exactly a load-state exit.
  always_ff @(posedge clk_i) begin
    if (rst_i)   word_cnt_q <= '0;
    else if (hs) word_cnt_q <= load_last ? '0 : word_cnt_q + CNT_W'(1);
  end

  // Queue empties are stale just after START; hold off for two RUN cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_RUN) run_hold_q <= 2'd0;
    else if (!run_settled)          run_hold_q <= run_hold_q + 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_DRAIN) drain_cnt_q <= '0;
    else                              drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] run_cnt_q;
  logic            err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_RUN) run_cnt_q <= '0;
    else                            run_cnt_q <= run_cnt_q + TO_W'(1);
  end

  assign timeout_hit = (state_q == ST_RUN) && (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)            err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  // Watchdog limit is only meaningful in the timeout build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
`endif

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (go_i) state_d = ST_CLEAR;
      ST_CLEAR:    state_d = ST_LOAD_COL;
      ST_LOAD_COL: if (load_last) state_d = ST_LOAD_ROW;
      ST_LOAD_ROW: if (load_last) state_d = ST_START;
      ST_START:    state_d = ST_RUN;
      ST_RUN: begin
        if (timeout_hit)                                     state_d = ST_DONE;
        else if (run_settled && col_empty_i && row_empty_i) state_d = ST_DRAIN;
      end
      ST_DRAIN:    if (drain_last) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o   = 1'b0;
    col_we_o     = 1'b0;
    col_wdata_o  = '0;
    col_wreset_o = 1'b0;
    row_we_o     = 1'b0;
    row_wdata_o  = '0;
    row_wreset_o = 1'b0;
    col_start_o  = 1'b0;
    row_start_o  = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        col_wreset_o = 1'b1;
        row_wreset_o = 1'b1;
      end
      ST_LOAD_COL: begin
        in_ready_o  = 1'b1;
        col_we_o    = in_valid_i;
        col_wdata_o = in_valid_i ? in_data_i : '0;
      end
      ST_LOAD_ROW: begin
        in_ready_o  = 1'b1;
        row_we_o    = in_valid_i;
        row_wdata_o = in_valid_i ? in_data_i : '0;
      end
      ST_START: begin
        col_start_o = 1'b1;
        row_start_o = 1'b1;
      end
      ST_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_queue_load_scheduler.sv
// Self-checking bench for queue_load_scheduler (N=4): reset/handshake vector table,
// scripted job scenarios and random jobs checked against a job-level timing model.
module tb_queue_load_scheduler;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int DRAIN   = 3;
  localparam int TIMEOUT = 20;
  localparam int WORDS   = N * N;
  localparam int NEVER   = 1_000_000;

  logic          clk = 1'b0;
  logic          rst, go, valid;
  logic [DW-1:0] data;
  logic          ready, col_we, col_wreset, row_we, row_wreset;
  logic [DW-1:0] col_wdata, row_wdata;
  logic          col_start, row_start, col_empty, row_empty;
  logic          busy, done, err;
  logic [2:0]    state;

  queue_load_scheduler #(
    .N(N), .DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .in_valid_i(valid), .in_data_i(data),
    .in_ready_o(ready),
    .col_we_o(col_we), .col_wdata_o(col_wdata), .col_wreset_o(col_wreset),
    .row_we_o(row_we), .row_wdata_o(row_wdata), .row_wreset_o(row_wreset),
    .col_start_o(col_start), .row_start_o(row_start),
    .col_empty_i(col_empty), .row_empty_i(row_empty),
    .busy_o(busy), .done_o(done), .err_o(err), .state_o(state)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Observation log, filled on the falling edge while log_en is set.
  bit            log_en = 1'b0;
  logic [DW-1:0] col_log[$];
  logic [DW-1:0] row_log[$];
  int            wreset_log[$];
  int            start_log[$];
  int            done_log[$];
  int            drain_cyc;
  logic          done_err;
  int            inv_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    col_log.delete(); row_log.delete();
    wreset_log.delete(); start_log.delete(); done_log.delete();
    drain_cyc = -1; done_err = 1'b0; inv_bad = 0;
  endtask

  // One clock: sample on the falling edge, advance on the rising edge, return 1 time unit later.
  task automatic tick();
    @(negedge clk);
    if (log_en) begin
      if (col_we)     col_log.push_back(col_wdata);
      if (row_we)     row_log.push_back(row_wdata);
      if (col_wreset) wreset_log.push_back(cyc);
      if (col_start)  start_log.push_back(cyc);
      if (done) begin
        done_log.push_back(cyc);
        done_err = err;
      end
      if (state == 3'd6 && drain_cyc < 0) drain_cyc = cyc;
      if (!col_we && col_wdata != '0)               inv_bad++;
      if (!row_we && row_wdata != '0)               inv_bad++;
      if (col_we && state != 3'd2)                  inv_bad++;
      if (row_we && state != 3'd3)                  inv_bad++;
      if (ready != (state == 3'd2 || state == 3'd3)) inv_bad++;
      if (busy != (state != 3'd0))                  inv_bad++;
      if (col_wreset != (state == 3'd1) || row_wreset != (state == 3'd1)) inv_bad++;
      if (col_start != (state == 3'd4) || row_start != (state == 3'd4))   inv_bad++;
      if (done != (state == 3'd7))                  inv_bad++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Job-level model: go at cycle g, CLEAR at g+1, loading from g+2 with one word per
  // valid cycle, START the cycle after the 32nd word, empties honoured from the third
  // RUN cycle, DONE DRAIN+1 cycles after both empties are seen (or watchdog).
  task automatic run_job(input int vmode, input int col_rise, input int row_rise,
                         input bit go_in_run, input int watch);
    bit            vb[$];
    logic [DW-1:0] wd[$];
    logic [DW-1:0] cw[$];
    logic [DW-1:0] rw[$];
    int ones = 0;
    int g, s, col_t, row_t, c, done_exp, drain_exp, end_cyc, idx, bad;
    bit err_exp = 1'b0;
    while (ones < 2 * WORDS) begin
      bit            v;
      logic [DW-1:0] d;
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = (vb.size() % 2 == 0);
      else                 v = 1'($urandom_range(0, 1));
      d = (vmode == 2) ? DW'($urandom) : DW'(ones);
      vb.push_back(v);
      wd.push_back(d);
      if (v) begin
        if (ones < WORDS) cw.push_back(d);
        else              rw.push_back(d);
        ones++;
      end
    end
    g     = cyc;
    s     = g + 2 + vb.size();
    col_t = (col_rise < 0) ? NEVER : s + col_rise;
    row_t = (row_rise < 0) ? NEVER : s + row_rise;
    c     = (col_t > row_t) ? col_t : row_t;
    if (c < s + 3) c = s + 3;
    done_exp  = -1;
    drain_exp = -1;
    if (c < NEVER) begin
      done_exp  = c + DRAIN + 1;
      drain_exp = c + 1;
    end
`ifdef SCHED_TIMEOUT_EN
    if (c >= s + TIMEOUT) begin
      done_exp  = s + 1 + TIMEOUT;
      drain_exp = -1;
      err_exp   = 1'b1;
    end
`endif
    end_cyc = (done_exp >= 0) ? done_exp + 2 : s + 1 + watch;

    clear_log();
    log_en = 1'b1;
    for (int k = g; k <= end_cyc; k++) begin
      go  = (k == g) || (go_in_run && k == s + 2);
      idx = k - (g + 2);
      if (idx >= 0 && idx < vb.size()) begin
        valid = vb[idx];
        data  = wd[idx];
      end else begin
        valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        data  = DW'($urandom);
      end
      col_empty = (k >= col_t);
      row_empty = (k >= row_t);
      tick();
    end
    go = 1'b0; valid = 1'b0;
    log_en = 1'b0;

    check("col_word_count", col_log.size(), WORDS);
    check("row_word_count", row_log.size(), WORDS);
    bad = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (i < col_log.size() && col_log[i] !== cw[i]) bad++;
      if (i < row_log.size() && row_log[i] !== rw[i]) bad++;
    end
    check("word_values_bad", bad, 0);
    check("wreset_cycle", (wreset_log.size() == 1) ? wreset_log[0] : -1, g + 1);
    check("start_cycle", (start_log.size() == 1) ? start_log[0] : -1, s);
    if (done_exp >= 0) check("done_cycle", (done_log.size() == 1) ? done_log[0] : -1, done_exp);
    else               check("done_count", done_log.size(), 0);
    check("drain_entry", drain_cyc, drain_exp);
    if (done_exp >= 0) check("err_at_done", 32'(done_err), 32'(err_exp));
    check("invariant_violations", inv_bad, 0);
    #3;
    check("end_state", 32'(state), (done_exp >= 0) ? 32'd0 : 32'd5);
    check("end_err", 32'(err), 32'(err_exp));
    tick();
  endtask

  typedef struct {
    logic          rst, go, valid;
    logic [DW-1:0] data;
    logic [2:0]    st;
    logic          rdy, cwe;
    logic [DW-1:0] cwd;
    logic          wrst, busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    //          rst   go    valid data       st    rdy   cwe   cwd    wrst  busy
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'hAA,   3'd1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h55,   3'd2, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h11,   3'd2, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h22,   3'd2, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h33,   3'd2, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 32'h77,   3'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};

    rst = 1'b1; go = 1'b0; valid = 1'b0; data = '0;
    col_empty = 1'b0; row_empty = 1'b0;
    clear_log();
    tick();
    tick();

    // Reset, reset-over-go priority, CLEAR pulse, zero-latency column writes.
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; go = tbl[i].go; valid = tbl[i].valid; data = tbl[i].data;
      #3;
      if (i == 0)
        check("reset_all_outputs",
              $countones({ready, col_we, col_wdata, col_wreset, row_we, row_wdata, row_wreset,
                          col_start, row_start, busy, done, err, state}), 0);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
      check($sformatf("vec%0d_col_we", i), 32'(col_we), 32'(tbl[i].cwe));
      check($sformatf("vec%0d_col_wdata", i), col_wdata, tbl[i].cwd);
      check($sformatf("vec%0d_wreset", i), 32'(col_wreset), 32'(tbl[i].wrst));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      tick();
    end
    rst = 1'b0; go = 1'b0; valid = 1'b0;

    run_job(0, 4, 4, 1'b0, 0);   // back-to-back words 0..31
    run_job(1, 3, 3, 1'b0, 0);   // valid toggling every other cycle
    run_job(0, 2, 7, 1'b0, 0);   // col empty five cycles before row empty
    run_job(0, 5, 5, 1'b1, 0);   // go pulsed during RUN
    run_job(0, 0, 0, 1'b0, 0);   // empties already high at START

    // Abort in LOAD_ROW after 7 row words.
    begin
      clear_log();
      log_en = 1'b1;
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      for (int i = 0; i < WORDS + 7; i++) begin
        valid = 1'b1;
        data  = DW'(i);
        tick();
      end
      valid = 1'b0;
      rst   = 1'b1;
      #3;
      check("abort_state_before", 32'(state), 32'd3);
      tick();
      rst = 1'b0;
      #3;
      check("abort_state_after", 32'(state), 32'd0);
      check("abort_outputs_zero",
            $countones({ready, col_we, col_wdata, col_wreset, row_we, row_wdata, row_wreset,
                        col_start, row_start, busy, done, err}), 0);
      for (int i = 0; i < 4; i++) tick();
      log_en = 1'b0;
      check("abort_col_words", col_log.size(), WORDS);
      check("abort_row_words", row_log.size(), 7);
      check("abort_no_start", start_log.size(), 0);
      check("abort_no_done", done_log.size(), 0);
    end

    run_job(0, 1, 1, 1'b0, 0);   // fresh job after abort starts at col word 0

    for (int j = 0; j < 4; j++)
      run_job(2, int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), 1'b0, 0);

    // Empties never rise: watchdog in the timeout build, indefinite RUN otherwise.
    run_job(0, -1, -1, 1'b0, 30);
`ifdef SCHED_TIMEOUT_EN
    for (int i = 0; i < 3; i++) tick();
    #3;
    check("err_sticky", 32'(err), 32'd1);
    tick();
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    check("final_reset_state", 32'(state), 32'd0);
    check("final_reset_err", 32'(err), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
